// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Combines load-use hazard, data-memory busy and taken-branch information
// into per-stage register enables, an IF/ID flush and an ID/EX bubble.
// Keeps the multi-cycle state and saturating stall/flush statistics.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow, all requests evaluated
// LU_STALL | one-cycle load-use stall issued, hazard_req masked
// MEM_WAIT | pipeline frozen while data memory is busy
// RESUME   | first cycle after a memory wait, otherwise behaves as RUN
module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_req,
    input  logic             mem_busy,
    input  logic             branch_taken,
    input  logic             clr_stats,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        RESUME   = 2'd3
    } stateT;

    stateT curState;
    stateT nextState;
    logic  flushEvent;
    logic  stallEvent;

    // Priority decode: reset, then memory freeze, then branch, then load-use.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        flushEvent  = 1'b0;
        nextState   = RUN;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            nextState = MEM_WAIT;
        end else begin
            if (branch_taken) begin
                // Any pending hazard belongs to a squashed instruction.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flushEvent  = 1'b1;
            end else if (hazard_req && (curState != LU_STALL)) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                nextState   = LU_STALL;
            end
            // Leaving a memory wait always passes through RESUME.
            if (curState == MEM_WAIT) begin
                nextState = RESUME;
            end
        end
    end

    assign stallEvent = !reset && !pc_en;
    assign state      = curState;

    // State register and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            curState     <= RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            curState <= nextState;
            if (clr_stats) begin
                stall_cycles <= '0;
                flush_count  <= '0;
            end else begin
                if (stallEvent && (stall_cycles != '1)) begin
                    stall_cycles <= stall_cycles + CNT_W'(1);
                end
                if (flushEvent && (flush_count != '1)) begin
                    flush_count <= flush_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It consumes the load-use hazard request from the ID-stage hazard detector, the data-memory busy flag and the EX-stage branch decision. From these it drives per-stage register enables, the IF/ID flush and the ID/EX bubble. It holds the multi-cycle state, masking re-triggered load-use requests and sequencing memory-wait freezes, and it keeps saturating statistics counters.

## Interface
- CNT_W, 16, width of the statistics counters.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- hazard_req  input  1  load-use hazard from the ID detector (high = stall requested).
- mem_busy  input  1  data memory has not completed its access this cycle.
- branch_taken  input  1  EX stage resolved a taken branch or jump this cycle.
- clr_stats  input  1  synchronous clear of both counters.
- pc_en  output  1  PC register load enable.
- ifid_en  output  1  IF/ID register enable.
- idex_en, exmem_en, memwb_en  output  1 each  remaining pipeline register enables.
- ifid_flush  output  1  IF/ID loads a NOP.
- idex_bubble  output  1  ID/EX loads a NOP (control bits cleared).
- state  output  2  current state: RUN=0, LU_STALL=1, MEM_WAIT=2, RESUME=3.
- stall_cycles  output  CNT_W  number of cycles with pc_en=0, saturating.
- flush_count  output  CNT_W  number of taken-branch flushes, saturating.

## Operation
- Outputs are combinational from the current state and inputs. state and the counters are registered.
- Input priority, highest first: reset, mem_busy, branch_taken, hazard_req.
- reset=1: all stage enables=1, pc_en=0, ifid_flush=1, idex_bubble=1, so the pipeline fills with NOPs. Next state is RUN and both counters go to 0.
- mem_busy=1, in any state: all five enables=0 and no flush or bubble, so the whole pipeline is frozen. Next state is MEM_WAIT.
- MEM_WAIT with mem_busy=0: the register enables are all 1 and the state goes to RESUME. branch_taken and hazard_req are evaluated exactly as in RUN during this cycle, including their output effects and the counter increments. Their state transitions are overridden by RESUME.
- RESUME: behaves exactly as RUN. It exists so software can observe the wait end. The next state follows the RUN rules.
- RUN or RESUME with branch_taken=1: all enables=1, ifid_flush=1, idex_bubble=1, flush_count+1. hazard_req is ignored because the hazard comes from a squashed instruction. Next state is RUN.
- RUN or RESUME with hazard_req=1 and no branch: pc_en=0, ifid_en=0, idex_bubble=1, other enables=1. Next state is LU_STALL.
- LU_STALL: hazard_req is masked, so a load-use stall lasts exactly one cycle. All enables are 1. branch_taken is still honoured as in RUN. Next state is RUN, unless mem_busy is high.
- Otherwise all enables are 1, there is no flush or bubble, and the state is RUN.
- stall_cycles increments in every non-reset cycle with pc_en=0, which includes MEM_WAIT freeze cycles. Both counters saturate at 2^CNT_W-1. clr_stats has priority over the increment in the same cycle.

## Timing
- Zero-cycle latency from inputs to enables and flush. The state transition takes effect on the next edge.
- A load-use stall costs exactly 1 cycle. A memory wait of N busy cycles costs N frozen cycles.
- mem_busy together with branch_taken: the freeze wins, and branch_taken must be held by EX. It is honoured on the first non-busy cycle, with no flush during the freeze.
- Reset asserted mid-stall or mid-wait: the reset outputs apply in that cycle and RUN follows.
- Counter saturation: at the all-ones value a further event leaves the counter unchanged, with no wrap.

## Test plan
- Reset held for 2 cycles, then released: pc_en=0 and flush/bubble=1 during reset, state=0 and both counters 0 afterwards. The first free cycle has all enables=1.
- hazard_req held high for 3 cycles: cycle 1 gives pc_en=ifid_en=0, idex_bubble=1, state→1. Cycle 2 has all enables=1 (masked). Cycle 3 stalls again. stall_cycles=2.
- branch_taken and hazard_req high together in RUN: ifid_flush=idex_bubble=1, pc_en=1, flush_count=1, stall_cycles=0, state stays 0.
- mem_busy for 4 cycles with branch_taken also high: 4 frozen cycles with no flush and state=2. The next cycle flushes, flush_count=1, stall_cycles=4, state→3.
- CNT_W=4: drive 17 stall cycles, then stall_cycles=15. clr_stats asserted together with a stall event gives 0.
- Reset asserted during MEM_WAIT: the reset outputs apply immediately and state=0 on the next edge.
